cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/step/halt sequencer for the minisys single-cycle CPU. It produces the single clock-enable `cpu_en`, which gates PC update, register-file write, data-memory write and LED write, so the whole datapath advances one instruction per enabled cycle. It owns the debounced confirm button and uses it for three things: single-stepping, resuming from a breakpoint, and acknowledging switch-input reads (`IORead`). It sits in the top level between the board inputs and IFetch/Decoder/Data_mem/leds.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change. Benches use 4.
- `ISA_WIDTH`, default 32 (`` `ISA_WIDTH``): PC and breakpoint width.

Ports:
- `clock`  in  1: CPU clock (clk1). This is the only clock.
- `rst`  in  1: reset, synchronous, active-high.
- `confirm_button`  in  1: raw, asynchronous push button.
- `mode_sw`  in  2: run mode. 00 = halt, 01 = run, 10 = step, 11 = run with breakpoint.
- `pc`  in  32: address of the current instruction, from IFetch.
- `bp_addr`  in  32: breakpoint address. Only used in mode 11.
- `io_wait_req`  in  1: the current instruction reads switches (Controller `IORead`).
- `cpu_en`  out  1: datapath enable. The current instruction commits at the next edge.
- `io_ack`  out  1: the user confirmed the switch value. Asserted only together with `cpu_en`.
- `halted`  out  1: state is HALT or BREAK.
- `state_out`  out  3: current state encoding, for LEDs or debug.
- `insn_count`  out  32: number of instructions committed.

## Operation
- **Button path:**
  - 2-flop synchronizer feeds a debounce counter.
  - The stable level flips after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing sample clears the counter.
  - `btn_pulse` = stable rose this cycle. It lasts exactly 1 cycle per press; release produces no pulse.
- **States** (registered): HALT=0, RUN=1, STEP=2, IO_WAIT=3, BREAK=4. Codes 5–7 are unreachable and recover to HALT.
- **Signal timing:** `cpu_en` and `io_ack` are combinational from the registered state and current inputs. `cpu_en` is forced to 0 whenever `rst` or `mode_sw==00`.
- **bp_hit** = (`mode_sw==11`) & (`pc==bp_addr`).
- **HALT:**
  - `cpu_en`=0.
  - mode 01/11 → RUN; mode 10 → STEP.
- **RUN:**
  - If bp_hit → BREAK, `cpu_en`=0. This has priority over io_wait_req.
  - Else if io_wait_req → IO_WAIT, `cpu_en`=0.
  - Else `cpu_en`=1.
  - mode 10 → STEP; mode 00 → HALT.
- **STEP:**
  - `cpu_en` = `btn_pulse`.
  - `io_ack` = `btn_pulse & io_wait_req`, so one press both supplies the switch value and steps.
  - mode 01/11 → RUN; mode 00 → HALT.
- **IO_WAIT:**
  - `cpu_en` = `io_ack` = `btn_pulse`.
  - On pulse: → RUN if mode 01/11, → STEP if mode 10.
  - mode 00 → HALT, aborting the wait without commit.
- **BREAK:**
  - `cpu_en` = `btn_pulse`, which executes the instruction at `bp_addr`.
  - `io_ack` = `btn_pulse & io_wait_req`.
  - On pulse → RUN.
  - mode 01 → RUN; mode 10 → STEP; mode 00 → HALT.
  - A self-loop at `bp_addr` re-enters BREAK after each commit. This is intended.
- **Ignored button presses:** `btn_pulse` in HALT or RUN has no effect.
- **Counter:** `insn_count` increments on every cycle where `cpu_en`=1. It wraps from 0xFFFF_FFFF to 0.
- **Outputs:** `halted` = (state==HALT) | (state==BREAK). `state_out` = state.

## Timing
- **Reset values:** after any edge with `rst`=1, state=HALT, `insn_count`=0, debounce counter=0, stable level=0. Outputs: `cpu_en`=0, `io_ack`=0, `halted`=1, `state_out`=0.
- **Reset mid-operation** (IO_WAIT, BREAK, mid-debounce) discards everything. No commit happens in the reset cycle.
- **Button latency:** with `confirm_button` held high from edge 1, `btn_pulse` is high in the cycle after edge `DEBOUNCE_CYCLES`+2.
- **Mode latency:** a mode change takes effect on the state at the next edge. `mode_sw==00` gates `cpu_en` in the same cycle.
- **RUN commit rate:** one instruction per cycle, i.e. `cpu_en` high continuously absent stops.
- **IO_WAIT commit:** exactly one commit per accepted press.
- **Simultaneous events:** bp_hit with io_wait_req → BREAK first; the resume press then asserts both `cpu_en` and `io_ack`.

## Structure
- State codes (`` `CTRL_HALT`` … `` `CTRL_BREAK``) and `` `CTRL_MODE_*`` constants live in `definitions.v`.
- Sub-module `button_debounce` (clock, rst, raw in → stable, pulse out), parameterized by `DEBOUNCE_CYCLES`.

## Test plan
`DEBOUNCE_CYCLES`=4 throughout.

- **Run then halt:** reset, mode 01 for 10 cycles → `cpu_en` high from cycle 2, `insn_count`=9 after 10 cycles. Mode 00 → `cpu_en` low same cycle, HALT next.
- **Step:** mode 10, three presses each held 10 cycles → exactly 3 one-cycle `cpu_en` pulses, each 6 edges after its press; `insn_count`=3. A glitch of 3 cycles → no pulse.
- **IO wait:** mode 01 with io_wait_req=1 → IO_WAIT, `cpu_en`=0 indefinitely. Press → one cycle with `cpu_en`=`io_ack`=1, then RUN.
- **Breakpoint:** mode 11, `bp_addr`=0x0000_0010, pc=0x10 → BREAK, `halted`=1, `state_out`=4. Press → one commit. pc=0x14 → RUN.
- **Breakpoint with IO wait:** bp_hit plus io_wait_req → BREAK. Press → `cpu_en`=`io_ack`=1 together.
- **Edge cases:** preload `insn_count` near 0xFFFF_FFFF (force) → wraps to 0. Reset asserted in IO_WAIT and BREAK → HALT with zero count.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the minisys run/step/halt sequencer: state codes, run modes, widths.
package cpu_run_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned COUNT_W = 32;

  typedef enum logic [STATE_W-1:0] {
    CTRL_HALT    = 3'd0,
    CTRL_RUN     = 3'd1,
    CTRL_STEP    = 3'd2,
    CTRL_IO_WAIT = 3'd3,
    CTRL_BREAK   = 3'd4
  } ctrl_state_e;

  typedef enum logic [MODE_W-1:0] {
    CTRL_MODE_HALT   = 2'b00,
    CTRL_MODE_RUN    = 2'b01,
    CTRL_MODE_STEP   = 2'b10,
    CTRL_MODE_RUN_BP = 2'b11
  } ctrl_mode_e;

  // Both free-running modes (plain run and run-with-breakpoint).
  function automatic logic mode_runs(input ctrl_mode_e mode);
    return (mode == CTRL_MODE_RUN) || (mode == CTRL_MODE_RUN_BP);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board/datapath-side signals of the run controller; master drives inputs, slave is the controller.
interface cpu_run_ctrl_if #(
  parameter int unsigned ISA_WIDTH = 32
);
  import cpu_run_ctrl_pkg::*;

  logic                   confirm_button;
  logic [MODE_W-1:0]      mode_sw;
  logic [ISA_WIDTH-1:0]   pc;
  logic [ISA_WIDTH-1:0]   bp_addr;
  logic                   io_wait_req;
  logic                   cpu_en;
  logic                   io_ack;
  logic                   halted;
  logic [STATE_W-1:0]     state_out;
  logic [COUNT_W-1:0]     insn_count;

  modport master (
    output confirm_button, mode_sw, pc, bp_addr, io_wait_req,
    input  cpu_en, io_ack, halted, state_out, insn_count
  );

  modport slave (
    input  confirm_button, mode_sw, pc, bp_addr, io_wait_req,
    output cpu_en, io_ack, halted, state_out, insn_count
  );

endinterface

// File: rtl/cpu_run_ctrl_button_debounce.sv
// Synchronizes and debounces the confirm button; emits a one-cycle pulse per accepted press.
module cpu_run_ctrl_button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic rst,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level flips after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
        pulse_d  = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer producing the single datapath enable for the minisys CPU.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned ISA_WIDTH       = 32
) (
  input  logic           clock,
  input  logic           rst,
  cpu_run_ctrl_if.slave  bus
);

  logic                 btn_pulse;
  ctrl_state_e          state_q, state_d;
  ctrl_mode_e           mode;
  logic [ISA_WIDTH-1:0] pc_w, bp_w;
  logic                 bp_hit;
  logic                 cpu_en_c, io_ack_c;
  logic [COUNT_W-1:0]   insn_count_q, insn_count_d;

  cpu_run_ctrl_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .rst    (rst),
    .raw_i  (bus.confirm_button),
    .pulse_o(btn_pulse)
  );

  assign mode   = ctrl_mode_e'(bus.mode_sw);
  assign pc_w   = bus.pc;
  assign bp_w   = bus.bp_addr;
  assign bp_hit = (mode == CTRL_MODE_RUN_BP) && (pc_w == bp_w);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= CTRL_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: mode changes take effect at the next edge; breakpoint outranks an IO wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_HALT: begin
        if (mode_runs(mode))             state_d = CTRL_RUN;
        else if (mode == CTRL_MODE_STEP) state_d = CTRL_STEP;
      end
      CTRL_RUN: begin
        if (mode == CTRL_MODE_HALT)      state_d = CTRL_HALT;
        else if (mode == CTRL_MODE_STEP) state_d = CTRL_STEP;
        else if (bp_hit)                 state_d = CTRL_BREAK;
        else if (bus.io_wait_req)        state_d = CTRL_IO_WAIT;
      end
      CTRL_STEP: begin
        if (mode == CTRL_MODE_HALT)      state_d = CTRL_HALT;
        else if (mode_runs(mode))        state_d = CTRL_RUN;
      end
      CTRL_IO_WAIT: begin
        if (mode == CTRL_MODE_HALT)      state_d = CTRL_HALT;
        else if (btn_pulse)              state_d = (mode == CTRL_MODE_STEP) ? CTRL_STEP : CTRL_RUN;
      end
      CTRL_BREAK: begin
        if (mode == CTRL_MODE_HALT)      state_d = CTRL_HALT;
        else if (mode == CTRL_MODE_STEP) state_d = CTRL_STEP;
        else if ((mode == CTRL_MODE_RUN) || btn_pulse) state_d = CTRL_RUN;
      end
      default:                           state_d = CTRL_HALT;
    endcase
  end

  // Enable and IO acknowledge; halt mode and reset kill both in the same cycle.
  always_comb begin
    cpu_en_c = 1'b0;
    io_ack_c = 1'b0;
    case (state_q)
      CTRL_RUN:     cpu_en_c = ~bp_hit & ~bus.io_wait_req;
      CTRL_STEP,
      CTRL_BREAK: begin
        cpu_en_c = btn_pulse;
        io_ack_c = btn_pulse & bus.io_wait_req;
      end
      CTRL_IO_WAIT: begin
        cpu_en_c = btn_pulse;
        io_ack_c = btn_pulse;
      end
      default: ;
    endcase
    if (rst || (mode == CTRL_MODE_HALT)) begin
      cpu_en_c = 1'b0;
      io_ack_c = 1'b0;
    end
  end

  always_comb begin
    insn_count_d = insn_count_q;
    if (cpu_en_c) insn_count_d = insn_count_q + COUNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      insn_count_q <= '0;
    end else begin
      insn_count_q <= insn_count_d;
    end
  end

  assign bus.cpu_en     = cpu_en_c;
  assign bus.io_ack     = io_ack_c;
  assign bus.halted     = (state_q == CTRL_HALT) || (state_q == CTRL_BREAK);
  assign bus.state_out  = STATE_W'(state_q);
  assign bus.insn_count = insn_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: commit scoreboard plus per-cycle state/enable checks.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  typedef struct packed {
    logic        io_ack;
    logic [31:0] pc;
    logic [31:0] cnt;
  } commit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.ISA_WIDTH(32)) bus();

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ISA_WIDTH      (32)
  ) dut (
    .clock(clk),
    .rst  (rst),
    .bus  (bus)
  );

  commit_t exp_q[$];
  commit_t got_e;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ack, input logic [31:0] pc, input logic [31:0] cnt);
    commit_t e;
    e.io_ack = ack;
    e.pc     = pc;
    e.cnt    = cnt;
    exp_q.push_back(e);
  endtask

  // Commit monitor: every enabled cycle must match the next expected commit.
  always @(negedge clk) begin
    if (bus.cpu_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_commit: got cpu_en=1 pc=0x%08h expected no commit at %0t", bus.pc, $time);
      end else begin
        got_e = exp_q.pop_front();
        chk("commit_io_ack", 32'(bus.io_ack), 32'(got_e.io_ack));
        chk("commit_pc", bus.pc, got_e.pc);
        chk("commit_count", bus.insn_count, got_e.cnt);
      end
    end else if (bus.io_ack === 1'b1) begin
      chk("io_ack_without_cpu_en", 32'(bus.io_ack), 32'd0);
    end
  end

  // Press held 10 cycles; pulse expected 6 edges after press; pc/io inputs updated right after the commit.
  task automatic press_and_watch(input logic exp_ack, input logic [31:0] pc_after, input logic io_after,
                                 input logic [2:0] st7, input logic [2:0] st8);
    bus.confirm_button = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        bus.pc          = pc_after;
        bus.io_wait_req = io_after;
      end
      if (i == 10) bus.confirm_button = 1'b0;
      #1;
      chk("press_cpu_en", 32'(bus.cpu_en), 32'(i == 6));
      if (i == 6) chk("press_io_ack", 32'(bus.io_ack), 32'(exp_ack));
      if (i == 7) chk("press_state_after", 32'(bus.state_out), 32'(st7));
      if (i == 8) chk("press_state_next", 32'(bus.state_out), 32'(st8));
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.confirm_button = 1'b0;
    bus.mode_sw        = 2'b00;
    bus.pc             = 32'h0;
    bus.bp_addr        = 32'h0;
    bus.io_wait_req    = 1'b0;
    rst = 1'b1;
    step();
    step();
    #1;
    chk("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    rst = 1'b0;
    step();
    #1;
    chk("reset_state", 32'(bus.state_out), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd1);
    chk("reset_count", bus.insn_count, 32'd0);
    chk("reset_cpu_en", 32'(bus.cpu_en), 32'd0);
    chk("reset_io_ack", 32'(bus.io_ack), 32'd0);

    // Run for 10 cycles, then halt
    bus.mode_sw = 2'b01;
    bus.pc      = 32'h100;
    #1;
    chk("run_first_cycle_cpu_en", 32'(bus.cpu_en), 32'd0);
    for (int k = 0; k < 9; k++) push(1'b0, 32'h100, 32'(k));
    step();
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("run_cpu_en", 32'(bus.cpu_en), 32'd1);
      step();
    end
    bus.mode_sw = 2'b00;
    #1;
    chk("run_count", bus.insn_count, 32'd9);
    chk("halt_gates_same_cycle", 32'(bus.cpu_en), 32'd0);
    chk("halt_state_not_yet", 32'(bus.state_out), 32'd1);
    step();
    #1;
    chk("halt_state", 32'(bus.state_out), 32'd0);
    chk("halt_halted", 32'(bus.halted), 32'd1);

    // Single step: three presses, then a short glitch
    bus.mode_sw = 2'b10;
    step();
    #1;
    chk("step_state", 32'(bus.state_out), 32'd2);
    chk("step_idle_cpu_en", 32'(bus.cpu_en), 32'd0);
    for (int p = 0; p < 3; p++) begin
      push(1'b0, 32'h100, 32'(9 + p));
      press_and_watch(1'b0, 32'h100, 1'b0, 3'd2, 3'd2);
    end
    #1;
    chk("step_count", bus.insn_count, 32'd12);
    bus.confirm_button = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) bus.confirm_button = 1'b0;
      #1;
      chk("glitch_cpu_en", 32'(bus.cpu_en), 32'd0);
      step();
    end

    // IO wait in run mode
    bus.mode_sw     = 2'b01;
    bus.io_wait_req = 1'b1;
    step();
    #1;
    chk("io_run_state", 32'(bus.state_out), 32'd1);
    chk("io_run_cpu_en", 32'(bus.cpu_en), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("io_wait_state", 32'(bus.state_out), 32'd3);
      chk("io_wait_cpu_en", 32'(bus.cpu_en), 32'd0);
      step();
    end
    push(1'b1, 32'h100, 32'd12);
    press_and_watch(1'b1, 32'h100, 1'b1, 3'd1, 3'd3);

    // Breakpoint
    bus.mode_sw = 2'b00;
    step();
    #1;
    chk("bp_pre_halt", 32'(bus.state_out), 32'd0);
    bus.mode_sw     = 2'b11;
    bus.pc          = 32'h10;
    bus.bp_addr     = 32'h10;
    bus.io_wait_req = 1'b0;
    step();
    #1;
    chk("bp_run_state", 32'(bus.state_out), 32'd1);
    chk("bp_run_cpu_en", 32'(bus.cpu_en), 32'd0);
    step();
    #1;
    chk("bp_state", 32'(bus.state_out), 32'd4);
    chk("bp_halted", 32'(bus.halted), 32'd1);
    chk("bp_cpu_en", 32'(bus.cpu_en), 32'd0);
    push(1'b0, 32'h10, 32'd13);
    press_and_watch(1'b0, 32'h14, 1'b1, 3'd1, 3'd3);

    // Breakpoint coinciding with an IO read
    bus.mode_sw = 2'b00;
    step();
    #1;
    chk("bpio_pre_halt", 32'(bus.state_out), 32'd0);
    bus.mode_sw     = 2'b11;
    bus.pc          = 32'h10;
    bus.io_wait_req = 1'b1;
    step();
    #1;
    chk("bpio_run_cpu_en", 32'(bus.cpu_en), 32'd0);
    step();
    #1;
    chk("bpio_state_break", 32'(bus.state_out), 32'd4);
    push(1'b1, 32'h10, 32'd14);
    press_and_watch(1'b1, 32'h14, 1'b1, 3'd1, 3'd3);

    // Counter wrap
    bus.mode_sw     = 2'b00;
    bus.io_wait_req = 1'b0;
    step();
    #1;
    chk("wrap_pre_halt", 32'(bus.state_out), 32'd0);
    force dut.insn_count_q = 32'hFFFF_FFFD;
    step();
    release dut.insn_count_q;
    #1;
    chk("wrap_preload", bus.insn_count, 32'hFFFF_FFFD);
    bus.mode_sw = 2'b01;
    bus.pc      = 32'h200;
    push(1'b0, 32'h200, 32'hFFFF_FFFD);
    push(1'b0, 32'h200, 32'hFFFF_FFFE);
    push(1'b0, 32'h200, 32'hFFFF_FFFF);
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wrap_cpu_en", 32'(bus.cpu_en), 32'd1);
      step();
    end
    bus.mode_sw = 2'b00;
    #1;
    chk("wrap_count", bus.insn_count, 32'd0);
    step();

    // Reset while waiting for IO, mid-debounce
    bus.mode_sw     = 2'b01;
    bus.io_wait_req = 1'b1;
    step();
    step();
    #1;
    chk("rstio_state", 32'(bus.state_out), 32'd3);
    bus.confirm_button = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    chk("rstio_reset_cycle_cpu_en", 32'(bus.cpu_en), 32'd0);
    step();
    rst = 1'b0;
    bus.confirm_button = 1'b0;
    #1;
    chk("rstio_state_after", 32'(bus.state_out), 32'd0);
    chk("rstio_count", bus.insn_count, 32'd0);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("rstio_no_commit", 32'(bus.cpu_en), 32'd0);
      step();
    end
    #1;
    chk("rstio_rewait", 32'(bus.state_out), 32'd3);

    // Reset while in BREAK
    bus.mode_sw     = 2'b00;
    bus.io_wait_req = 1'b0;
    step();
    bus.mode_sw = 2'b11;
    bus.pc      = 32'h10;
    bus.bp_addr = 32'h10;
    step();
    step();
    #1;
    chk("rstbp_state", 32'(bus.state_out), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rstbp_state_after", 32'(bus.state_out), 32'd0);
    chk("rstbp_halted", 32'(bus.halted), 32'd1);
    chk("rstbp_count", bus.insn_count, 32'd0);

    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
